// File: rtl/dec_lut_pipe_if.sv
// Stream and configuration bundle for dec_lut_pipe. The block is the slave; a
// neighbouring datapath block or the testbench is the master.
interface dec_lut_pipe_if #(
  parameter int N_IN = 4,
  parameter int N_FN = 1
);
  localparam int D    = 1 << N_IN;
  localparam int FN_W = (N_FN > 1) ? $clog2(N_FN) : 1;

  logic            en;
  logic            en_l;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_x;
  logic            cfg_we;
  logic [FN_W-1:0] cfg_fn;
  logic [D-1:0]    cfg_mask;
  logic            out_valid;
  logic            out_ready;
  logic [N_FN-1:0] out_f;
  logic [D-1:0]    out_dec;

  modport master (
    output en, en_l, in_valid, in_x, cfg_we, cfg_fn, cfg_mask, out_ready,
    input  in_ready, out_valid, out_f, out_dec
  );

  modport slave (
    input  en, en_l, in_valid, in_x, cfg_we, cfg_fn, cfg_mask, out_ready,
    output in_ready, out_valid, out_f, out_dec
  );
endinterface

// File: rtl/dec_lut_pipe.sv
// Two-stage decoder-based sum-of-minterms generator with programmable masks.
// Optional per-function saturating hit counters are built with DEC_LUT_HITCNT_EN.
module dec_lut_pipe #(
  parameter int          N_IN      = 4,
  parameter int          N_FN      = 1,
  parameter logic [63:0] MASK_INIT = 64'h0000_0000_0000_F0F0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_lut_pipe_if.slave        bus
`ifdef DEC_LUT_HITCNT_EN
  ,
  output logic [16*N_FN-1:0]   hit_cnt
`endif
);
  localparam int           D        = 1 << N_IN;
  localparam int           FN_W     = (N_FN > 1) ? $clog2(N_FN) : 1;
  localparam logic [D-1:0] MASK_RST = MASK_INIT[D-1:0];

  logic                     adv_s;
  logic [D-1:0]             dec1_d;
  logic [D-1:0]             dec1_q;
  logic                     v1_q;
  logic                     out_valid_q;
  logic [D-1:0]             out_dec_q;
  logic [N_FN-1:0]          out_f_d;
  logic [N_FN-1:0]          out_f_q;
  logic [N_FN-1:0][D-1:0]   mask_q;
  logic [N_FN-1:0]          mask_we_s;

  // Both stages move together; a full, stalled output freezes the pipe.
  assign adv_s         = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dec   = out_dec_q;
  assign bus.out_f     = out_f_q;

  // One-hot decode of the select word, gated by both enables.
  always_comb begin
    dec1_d = '0;
    if (bus.en && !bus.en_l) begin
      dec1_d[bus.in_x] = 1'b1;
    end else begin
      dec1_d = '0;
    end
  end

  // Function evaluation against the current masks and per-function write strobes.
  always_comb begin
    out_f_d   = '0;
    mask_we_s = '0;
    for (int k = 0; k < N_FN; k++) begin
      out_f_d[k]   = |(dec1_q & mask_q[k]);
      mask_we_s[k] = bus.cfg_we && (bus.cfg_fn == FN_W'(k));
    end
  end

  // Stage 1: capture the decoded beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      dec1_q <= '0;
    end else if (adv_s) begin
      if (bus.in_valid) begin
        v1_q   <= 1'b1;
        dec1_q <= dec1_d;
      end else begin
        v1_q   <= 1'b0;
      end
    end
  end

  // Stage 2: registered outputs, masks sampled at the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
      out_f_q     <= '0;
    end else if (adv_s) begin
      out_valid_q <= v1_q;
      out_dec_q   <= dec1_q;
      out_f_q     <= out_f_d;
    end
  end

  // Mask registers; writes ignore the stall, so a same-edge transfer sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FN; k++) begin
        mask_q[k] <= MASK_RST;
      end
    end else begin
      for (int k = 0; k < N_FN; k++) begin
        if (mask_we_s[k]) begin
          mask_q[k] <= bus.cfg_mask;
        end
      end
    end
  end

`ifdef DEC_LUT_HITCNT_EN
  logic [N_FN-1:0][15:0] hit_q;
  logic                  fire_s;

  assign fire_s = out_valid_q && bus.out_ready;

  // Saturating hit counters; a mask write to the same function clears and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else begin
      for (int k = 0; k < N_FN; k++) begin
        if (mask_we_s[k]) begin
          hit_q[k] <= 16'h0000;
        end else if (fire_s && out_f_q[k] && (hit_q[k] != 16'hFFFF)) begin
          hit_q[k] <= hit_q[k] + 16'd1;
        end
      end
    end
  end

  assign hit_cnt = hit_q;
`endif
endmodule

// File: tb/tb_dec_lut_pipe.sv
// Randomised and directed bench for dec_lut_pipe against a beat-level reference model.
module tb_dec_lut_pipe;
  localparam int N_IN = 4;
  localparam int N_FN = 3;
  localparam int D    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_lut_pipe_if #(.N_IN(N_IN), .N_FN(N_FN)) bus ();
`ifdef DEC_LUT_HITCNT_EN
  logic [16*N_FN-1:0] hit_cnt;
`endif

  dec_lut_pipe #(.N_IN(N_IN), .N_FN(N_FN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEC_LUT_HITCNT_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [3:0] x; bit e; } beat_t;

  // Reference model: a beat sits in one of two slots; functions are truth-table lookups.
  logic [15:0] m_mask [N_FN];
  int          m_hits [N_FN];
  bit          m_v1, m_e1, m_ov, m_eo, m_acc;
  logic [3:0]  m_x1, m_xo;
  logic [2:0]  m_fo;
  beat_t       sb_q[$];
  logic [15:0] seen_dec[$];
  logic [2:0]  seen_f[$];

  function automatic logic [15:0] exp_dec(logic [3:0] x, bit e);
    return e ? (16'd1 << x) : 16'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_FN; k++) begin
      m_mask[k] = 16'hF0F0;
      m_hits[k] = 0;
    end
    m_v1 = 1'b0;
    m_ov = 1'b0;
    sb_q.delete();
  endtask

  task automatic tick();
    beat_t b;
    bit fire, adv;
    #1;
    check("in_ready", bus.in_ready, !m_ov || bus.out_ready);
    check("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check("out_dec", bus.out_dec, exp_dec(m_xo, m_eo));
      check("out_f", bus.out_f, m_fo);
      if (bus.out_ready) begin
        if (sb_q.size() > 0) begin
          b = sb_q.pop_front();
          check("order", bus.out_dec, exp_dec(b.x, b.e));
        end else begin
          check("sb_empty", 64'(sb_q.size()), 64'd1);
        end
        seen_dec.push_back(bus.out_dec);
        seen_f.push_back(bus.out_f);
      end
    end
`ifdef DEC_LUT_HITCNT_EN
    for (int k = 0; k < N_FN; k++) check("hit_cnt", hit_cnt[16*k +: 16], 64'(m_hits[k]));
`endif
    @(posedge clk);
    fire  = m_ov && bus.out_ready;
    adv   = !m_ov || bus.out_ready;
    m_acc = adv && bus.in_valid;
    for (int k = 0; k < N_FN; k++) begin
      if (bus.cfg_we && bus.cfg_fn == k) m_hits[k] = 0;
      else if (fire && m_fo[k] && m_hits[k] < 65535) m_hits[k]++;
    end
    if (adv) begin
      m_ov = m_v1;
      m_xo = m_x1;
      m_eo = m_e1;
      for (int k = 0; k < N_FN; k++) m_fo[k] = m_e1 && m_mask[k][m_x1];
      if (bus.in_valid) begin
        m_v1 = 1'b1;
        m_x1 = bus.in_x;
        m_e1 = bus.en && !bus.en_l;
        b.x  = bus.in_x;
        b.e  = m_e1;
        sb_q.push_back(b);
      end else begin
        m_v1 = 1'b0;
      end
    end
    if (bus.cfg_we && bus.cfg_fn < N_FN) m_mask[bus.cfg_fn] = bus.cfg_mask;
    #1;
  endtask

  task automatic drive(bit v, logic [3:0] x, bit e, bit el, bit rdy);
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.en        = e;
    bus.en_l      = el;
    bus.out_ready = rdy;
    bus.cfg_we    = 1'b0;
    tick();
  endtask

  task automatic send(logic [3:0] x, bit e, bit el);
    bit ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      drive(1'b1, x, e, el, 1'b1);
      ok = m_acc;
    end
    check("send_accept", ok, 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic cfg_write(logic [1:0] fn, logic [15:0] mask);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_fn    = fn;
    bus.cfg_mask  = mask;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic check_seen(string tag, logic [15:0] d[4], logic [2:0] f[4], int n);
    check({tag, "_count"}, 64'(seen_dec.size()), 64'(n));
    for (int i = 0; i < n && i < seen_dec.size(); i++) begin
      check({tag, "_dec"}, seen_dec[i], d[i]);
      check({tag, "_f"}, seen_f[i], f[i]);
    end
    seen_dec.delete();
    seen_f.delete();
  endtask

  initial begin
    logic [15:0] td[4];
    logic [2:0]  tf[4];
    bus.en = 1'b1; bus.en_l = 1'b0; bus.in_valid = 1'b0; bus.in_x = 4'h0;
    bus.cfg_we = 1'b0; bus.cfg_fn = 2'd0; bus.cfg_mask = 16'h0000; bus.out_ready = 1'b1;
    model_reset();
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_dec", bus.out_dec, 16'h0000);
    check("rst_out_f", bus.out_f, 3'b000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Default masks, basic stream
    idle(1);
    send(4'h4, 1'b1, 1'b0); send(4'hB, 1'b1, 1'b0);
    send(4'hD, 1'b1, 1'b0); send(4'h0, 1'b1, 1'b0);
    idle(3);
    td = '{16'h0010, 16'h0800, 16'h2000, 16'h0001};
    tf = '{3'b111, 3'b000, 3'b111, 3'b000};
    check_seen("stream", td, tf, 4);

    // Decode disabled by either enable
    send(4'h5, 1'b0, 1'b0); send(4'h5, 1'b1, 1'b1);
    idle(3);
    td = '{16'h0000, 16'h0000, 16'h0, 16'h0};
    tf = '{3'b000, 3'b000, 3'b0, 3'b0};
    check_seen("disabled", td, tf, 2);

    // Backpressure: three stalled cycles while four beats are offered
    drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    bus.in_x = 4'h3;
    #1;
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_hold_dec", bus.out_dec, 16'h0002);
    tick();
    check("bp_still_dec", bus.out_dec, 16'h0002);
    check("bp_still_valid", bus.out_valid, 1'b1);
    send(4'h3, 1'b1, 1'b0); send(4'h4, 1'b1, 1'b0);
    idle(3);
    td = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
    tf = '{3'b000, 3'b000, 3'b000, 3'b111};
    check_seen("bp", td, tf, 4);

    // Mask write racing a transfer uses the old mask
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'hF0F0);
    send(4'hF, 1'b1, 1'b0);
    cfg_write(2'd1, 16'h8001);
    idle(2);
    send(4'hF, 1'b1, 1'b0);
    idle(3);
    cfg_write(2'd3, 16'h0000);
    send(4'hF, 1'b1, 1'b0); send(4'h0, 1'b1, 1'b0);
    idle(3);
    td = '{16'h8000, 16'h8000, 16'h8000, 16'h0001};
    tf = '{3'b101, 3'b111, 3'b111, 3'b010};
    check_seen("mask", td, tf, 4);

    // Asynchronous reset with two beats in flight
    send(4'h1, 1'b1, 1'b0); send(4'h2, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_ready", bus.in_ready, 1'b1);
    check("mid_rst_dec", bus.out_dec, 16'h0000);
    model_reset();
    seen_dec.delete(); seen_f.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send(4'h0, 1'b1, 1'b0); send(4'hF, 1'b1, 1'b0);
    idle(3);
    td = '{16'h0001, 16'h8000, 16'h0, 16'h0};
    tf = '{3'b000, 3'b111, 3'b0, 3'b0};
    check_seen("post_rst", td, tf, 2);

    // Random traffic with stalls and configuration writes
    for (int i = 0; i < 500; i++) begin
      bus.cfg_we    = ($urandom_range(0, 7) == 0);
      bus.cfg_fn    = 2'($urandom_range(0, 3));
      bus.cfg_mask  = 16'($urandom);
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_x      = 4'($urandom);
      bus.en        = $urandom_range(0, 7) != 0;
      bus.en_l      = $urandom_range(0, 7) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.cfg_we = 1'b0;
    idle(3);

`ifdef DEC_LUT_HITCNT_EN
    // Saturation and clear-over-increment
    cfg_write(2'd0, 16'hFFFF);
    for (int i = 0; i < 70000; i++) drive(1'b1, 4'($urandom), 1'b1, 1'b0, 1'b1);
    check("hit_sat", hit_cnt[15:0], 16'hFFFF);
    bus.cfg_we   = 1'b1;
    bus.cfg_fn   = 2'd0;
    bus.cfg_mask = 16'hFFFF;
    tick();
    bus.cfg_we = 1'b0;
    #1;
    check("hit_clear", hit_cnt[15:0], 16'h0000);
    idle(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec_lut_pipe.md
# dec_lut_pipe

- Parametrised, pipelined, decoder-based Boolean function generator.
- Each `in_x` word is decoded to a one-hot minterm vector. `N_FN` independent functions are formed by OR-ing the minterms selected by per-function mask registers, which are runtime-programmable.
- A valid/ready stream connects it to neighbouring datapath blocks, and it is used wherever the design needs reconfigurable sum-of-minterms logic.
- Reset defaults reproduce f = B for a 4-input {A,B,C,D} bus, i.e. mask 16'hF0F0.

## Interface
Parameters:
- `N_IN`, default 4: number of select inputs; legal range 2..6. The decode width is D = 2^N_IN.
- `N_FN`, default 1: number of function outputs; legal range 1..4.
- `MASK_INIT`, default 16'hF0F0: reset value of every mask register, truncated or zero-extended to D bits.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `en`, in, 1: active-high decode enable; sampled with each input beat.
- `en_l`, in, 1: active-low decode enable; sampled with each input beat.
- `in_valid`, in, 1: input beat present.
- `in_ready`, out, 1: block accepts the input beat this cycle.
- `in_x`, in, N_IN: select word. The MSB is the first variable, e.g. A.
- `cfg_we`, in, 1: mask write strobe.
- `cfg_fn`, in, max(1,clog2(N_FN)): index of the function whose mask is written.
- `cfg_mask`, in, D: new minterm mask.
- `out_valid`, out, 1: output beat present.
- `out_ready`, in, 1: downstream accepts the output beat.
- `out_f`, out, N_FN: function results.
- `out_dec`, out, D: registered one-hot decode of the beat.
- `hit_cnt`, out, 16*N_FN: per-function hit counters. Present only with `DEC_LUT_HITCNT_EN`.

## Operation
- Pipeline advance: `adv = !out_valid || out_ready`.
- `in_ready = adv`.
- All stages hold their contents when `adv` = 0.
- Stage 1, on an accepted beat:
  - Register `dec1 = (en && !en_l) ? (1 << in_x) : 0`.
  - Register `v1 = 1`.
- Stage 1, when `adv` = 1 with no input beat: `v1 = 0`.
- Stage 2, when `adv` = 1:
  - `out_valid <= v1`.
  - `out_dec <= dec1`.
  - `out_f[k] <= |(dec1 & mask[k])` for each k.
- Mask timing: masks are read at the stage-1 to stage-2 transfer.
- Mask write:
  - When `cfg_we` = 1 and `cfg_fn` < N_FN, `mask[cfg_fn] <= cfg_mask`.
  - A write with `cfg_fn` ≥ N_FN is ignored.
  - Writes are accepted regardless of `adv`.
  - A transfer in the same cycle as a write uses the old mask; the new mask applies from the next edge.
- When the decode is disabled, `dec1` = 0, so `out_dec` = 0 and `out_f` = 0. The beat is still emitted with `out_valid` = 1.
- Beats are never dropped, duplicated or reordered.
- Reset values:
  - `out_valid` = 0, `out_f` = 0, `out_dec` = 0.
  - `v1` = 0, `dec1` = 0.
  - All masks = MASK_INIT.
  - `hit_cnt` = 0.
- Reset mid-operation: assertion of `rst_n` flushes in-flight beats immediately, because reset is asynchronous. `in_ready` = 1 while in reset.

## Timing
- Latency: 2 cycles. A beat accepted at edge n appears on `out_*` after edge n+1 and is visible for consumption at edge n+2.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- `in_ready` is combinational from `out_ready` and `out_valid`.
- There is no other combinational input-to-output path.
- A stall freezes both stages. The beat in stage 1 resumes when `out_ready` rises.

## Configuration
- Macro: `DEC_LUT_HITCNT_EN`.
- Defined:
  - Per function k, a 16-bit counter increments on each accepted output (`out_valid && out_ready`) with `out_f[k]` = 1.
  - The counter saturates at 16'hFFFF.
  - A valid `cfg_we` to function k clears counter k to 0. The clear wins over a same-cycle increment.
  - The counters drive `hit_cnt`, with counter k at bits [16k+15:16k].
- Undefined:
  - No counters are built.
  - The `hit_cnt` port is absent.
  - All other behaviour is identical.

## Test plan
- Reset, then default config with `en`=1, `en_l`=0, `out_ready`=1:
  - Stream `in_x` = 4'h4, 4'hB, 4'hD, 4'h0.
  - Required: `out_f` = 1, 0, 1, 0 and `out_dec` = 16'h0010, 16'h0800, 16'h2000, 16'h0001.
  - Each result arrives exactly 2 cycles after its input.
- Drive `en`=0 (and separately `en_l`=1) with `in_x` = 4'h5 -> `out_valid` = 1, `out_dec` = 0, `out_f` = 0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles while offering 4 beats.
  - Required: `in_ready` = 0 once both stages are full, and `out_*` stays stable.
  - After release, all 4 beats emerge in order with no loss.
- Mask write with `N_FN`=2:
  - Write `mask[1]` = 16'h8001 in the same cycle as a stage-1 to stage-2 transfer of `in_x` = 4'hF.
  - Required: that beat's `out_f[1]` = 0 (old mask 16'hF0F0 & bit 15 → 1 only via old mask; check with old mask 16'h0000 preloaded).
  - The next `in_x` = 4'hF beat gives `out_f[1]` = 1.
  - A write with `cfg_fn` = 3 leaves all masks unchanged.
- Async reset asserted mid-stream with 2 beats in flight -> `out_valid` = 0 immediately, masks = 16'hF0F0, no stale beat after release.
- With `DEC_LUT_HITCNT_EN`:
  - 70000 accepted hits give `hit_cnt` = 16'hFFFF.
  - A `cfg_we` to that function clears it to 0 in the same cycle as a hit.
